// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the step/burst clock-enable controller.
package step_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PC_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_STEP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/step_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous VIO level, followed by a
// registered one-cycle rising-edge pulse.
module step_ctrl_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_1   <= level;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
            rise     <= sync_2 & ~sync_2_d;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Converts VIO step/run/clear toggles into one-cycle CPU clock enables,
// with N-instruction bursts, PC breakpoints and fault halts.
//
// state | meaning
// IDLE  | waiting for a step or run request
// STEP  | single enable issued this cycle
// RUN   | burst in progress, one enable per cycle
// HALT  | stopped on breakpoint or fault, waiting for clear_halt
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             man_step,
    input  logic             run_req,
    input  logic             clear_halt,
    input  logic [CNT_W-1:0] run_count,
    input  logic             break_en,
    input  logic [PC_W-1:0]  break_pc,
    input  logic [PC_W-1:0]  pc,
    input  logic             fault,
    output logic             cpu_en,
    output logic             busy,
    output logic             halted_break,
    output logic             halted_fault,
    output logic [CNT_W-1:0] steps_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic step_rise;
    logic run_rise;
    logic clear_rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             halted_break_q, halted_break_d;
    logic             halted_fault_q, halted_fault_d;
    logic             cpu_en_q, cpu_en_d;
    logic             busy_q;
    logic             bp_hit;

    step_ctrl_sync_edge u_sync_step (
        .clk   (clk),
        .reset (reset),
        .level (man_step),
        .rise  (step_rise)
    );

    step_ctrl_sync_edge u_sync_run (
        .clk   (clk),
        .reset (reset),
        .level (run_req),
        .rise  (run_rise)
    );

    step_ctrl_sync_edge u_sync_clear (
        .clk   (clk),
        .reset (reset),
        .level (clear_halt),
        .rise  (clear_rise)
    );

    // Every RUN cycle has already issued an enable, and pc reflects it, so
    // the compare is only meaningful there; starting on the breakpoint runs past it.
    assign bp_hit = break_en && (pc == break_pc);

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        halted_break_d = halted_break_q;
        halted_fault_d = halted_fault_q;

        if (fault) begin
            state_d        = ST_HALT;
            halted_fault_d = 1'b1;
            remaining_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_rise) begin
                        if (run_count != '0) begin
                            state_d     = ST_RUN;
                            remaining_d = run_count;
                        end
                    end else if (step_rise) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (bp_hit) begin
                        state_d        = ST_HALT;
                        halted_break_d = 1'b1;
                        remaining_d    = '0;
                    end else if (remaining_q == CNT_ONE) begin
                        state_d     = ST_IDLE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - CNT_ONE;
                    end
                end
                ST_HALT: begin
                    if (clear_rise) begin
                        state_d        = ST_IDLE;
                        halted_break_d = 1'b0;
                        halted_fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        cpu_en_d = is_active(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            halted_break_q <= 1'b0;
            halted_fault_q <= 1'b0;
            cpu_en_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            halted_break_q <= halted_break_d;
            halted_fault_q <= halted_fault_d;
            cpu_en_q       <= cpu_en_d;
            busy_q         <= cpu_en_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps_done <= '0;
        end else if (cpu_en_q) begin
            steps_done <= steps_done + CNT_ONE;
        end
    end

    assign cpu_en       = cpu_en_q;
    assign busy         = busy_q;
    assign halted_break = halted_break_q;
    assign halted_fault = halted_fault_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: expected enable counts are queued when a
// request is driven and compared once the controller goes quiet.
module tb_step_ctrl;

    logic        clk;
    logic        reset;
    logic        man_step;
    logic        run_req;
    logic        clear_halt;
    logic [15:0] run_count;
    logic        break_en;
    logic [31:0] break_pc;
    logic [31:0] pc;
    logic        fault;
    logic        cpu_en;
    logic        busy;
    logic        halted_break;
    logic        halted_fault;
    logic [15:0] steps_done;

    int          total = 0;
    int          bad = 0;
    int          en_cnt = 0;
    int          base = 0;
    int          cur_run = 0;
    int          last_run = 0;
    logic [15:0] exp_steps = 16'h0;
    int          exp_q[$];

    step_ctrl #(.CNT_W(16), .PC_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .man_step     (man_step),
        .run_req      (run_req),
        .clear_halt   (clear_halt),
        .run_count    (run_count),
        .break_en     (break_en),
        .break_pc     (break_pc),
        .pc           (pc),
        .fault        (fault),
        .cpu_en       (cpu_en),
        .busy         (busy),
        .halted_break (halted_break),
        .halted_fault (halted_fault),
        .steps_done   (steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle, sampled at the falling edge; the CPU model advances its PC
    // inside every enabled cycle.
    task automatic tick();
        @(negedge clk);
        if (cpu_en === 1'b1) begin
            en_cnt++;
            pc = pc + 32'd4;
            cur_run++;
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    endtask

    task automatic launch(input bit s, input bit r, input bit c, input int exp_en);
        base = en_cnt;
        exp_q.push_back(exp_en);
        exp_steps = exp_steps + 16'(exp_en);
        if (s) man_step = 1'b1;
        if (r) run_req = 1'b1;
        if (c) clear_halt = 1'b1;
        repeat (3) tick();
        man_step   = 1'b0;
        run_req    = 1'b0;
        clear_halt = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        repeat (2) tick();
    endtask

    task automatic sb_pop(input string tag);
        int e;
        if (exp_q.size() == 0) e = -1;
        else e = exp_q.pop_front();
        check(tag, en_cnt - base, e);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        man_step   = 1'b0;
        run_req    = 1'b0;
        clear_halt = 1'b0;
        run_count  = 16'd0;
        break_en   = 1'b0;
        break_pc   = 32'h0;
        pc         = 32'h0;
        fault      = 1'b0;
        repeat (2) tick();
        check("rst_cpu_en", cpu_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hbrk", halted_break, 1'b0);
        check("rst_hflt", halted_fault, 1'b0);
        check("rst_steps", steps_done, 16'h0);
        reset = 1'b0;
        repeat (3) tick();

        // single step with latency: enable in the 4th cycle after the raise
        base = en_cnt;
        exp_q.push_back(1);
        exp_steps = exp_steps + 16'd1;
        man_step = 1'b1;
        repeat (3) tick();
        check("step_early", cpu_en, 1'b0);
        tick();
        check("step_en", cpu_en, 1'b1);
        check("step_busy", busy, 1'b1);
        tick();
        check("step_en_off", cpu_en, 1'b0);
        check("step_busy_off", busy, 1'b0);
        man_step = 1'b0;
        repeat (3) tick();
        sb_pop("step_count");
        check("step_steps", steps_done, exp_steps);

        // burst of 5 with a second run_req edge landing mid-burst
        run_count = 16'd5;
        base = en_cnt;
        exp_q.push_back(5);
        exp_steps = exp_steps + 16'd5;
        run_req = 1'b1;
        repeat (2) tick();
        run_req = 1'b0;
        tick();
        run_req = 1'b1;
        repeat (3) tick();
        run_req = 1'b0;
        wait_idle("burst5", 40);
        repeat (6) tick();
        sb_pop("burst5_count");
        check("burst5_consec", last_run, 5);
        check("burst5_steps", steps_done, exp_steps);

        run_count = 16'd0;
        launch(0, 1, 0, 0);
        wait_idle("burst0", 20);
        sb_pop("burst0_count");
        check("burst0_steps", steps_done, exp_steps);

        // breakpoint at 0x10 from PC 0: four enables then halt
        pc        = 32'h0;
        break_pc  = 32'h10;
        break_en  = 1'b1;
        run_count = 16'd20;
        launch(0, 1, 0, 4);
        wait_idle("brk", 40);
        sb_pop("brk_count");
        check("brk_flag", halted_break, 1'b1);
        check("brk_fault_flag", halted_fault, 1'b0);
        check("brk_pc", pc, 32'h10);
        launch(1, 0, 0, 0);
        wait_idle("brk_step_ign", 20);
        sb_pop("brk_step_ign_count");
        check("brk_flag_hold", halted_break, 1'b1);
        launch(0, 0, 1, 0);
        wait_idle("brk_clear", 20);
        sb_pop("brk_clear_count");
        check("brk_flag_clr", halted_break, 1'b0);
        run_count = 16'd3;
        launch(0, 1, 0, 3);
        wait_idle("brk_rerun", 40);
        sb_pop("brk_rerun_count");
        check("brk_rerun_pc", pc, 32'h1C);
        check("brk_rerun_flag", halted_break, 1'b0);
        break_en = 1'b0;

        // fault raised inside the 3rd enable cycle of a burst
        run_count = 16'd10;
        base = en_cnt;
        exp_q.push_back(3);
        exp_steps = exp_steps + 16'd3;
        run_req = 1'b1;
        n = 0;
        while ((en_cnt - base) < 3 && n < 40) begin
            tick();
            n++;
        end
        check("flt_reach3", en_cnt - base, 3);
        fault   = 1'b1;
        run_req = 1'b0;
        tick();
        check("flt_en_off", cpu_en, 1'b0);
        check("flt_flag", halted_fault, 1'b1);
        check("flt_brk_flag", halted_break, 1'b0);
        repeat (4) tick();
        sb_pop("flt_count");
        launch(0, 0, 1, 0);
        repeat (3) tick();
        sb_pop("flt_clear_ign_count");
        check("flt_clear_ign", halted_fault, 1'b1);
        fault = 1'b0;
        repeat (3) tick();
        launch(0, 0, 1, 0);
        wait_idle("flt_clear", 20);
        sb_pop("flt_clear_count");
        check("flt_flag_clr", halted_fault, 1'b0);
        launch(1, 0, 0, 1);
        wait_idle("flt_post_step", 20);
        sb_pop("flt_post_step_count");
        check("flt_steps", steps_done, exp_steps);

        // reset after 40 enables of a 100-long burst
        run_count = 16'd100;
        base = en_cnt;
        exp_q.push_back(40);
        run_req = 1'b1;
        n = 0;
        while ((en_cnt - base) < 40 && n < 200) begin
            tick();
            n++;
        end
        reset   = 1'b1;
        run_req = 1'b0;
        #1;
        sb_pop("rstmid_count");
        check("rstmid_en_async", cpu_en, 1'b0);
        tick();
        check("rstmid_en", cpu_en, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_steps", steps_done, 16'h0);
        check("rstmid_hbrk", halted_break, 1'b0);
        check("rstmid_hflt", halted_fault, 1'b0);
        tick();
        reset = 1'b0;
        exp_steps = 16'h0;
        base = en_cnt;
        exp_q.push_back(0);
        repeat (20) tick();
        sb_pop("rstmid_no_resume");
        check("rstmid_steps_after", steps_done, 16'h0);

        // fill steps_done to all-ones, then a simultaneous step+run of 2 wraps it
        run_count = 16'hFFFF;
        launch(0, 1, 0, 65535);
        wait_idle("fill", 70000);
        sb_pop("fill_count");
        check("fill_steps", steps_done, 16'hFFFF);
        run_count = 16'd2;
        launch(1, 1, 0, 2);
        wait_idle("simul", 40);
        sb_pop("simul_count");
        check("simul_consec", last_run, 2);
        check("wrap_steps", steps_done, 16'h0001);
        check("wrap_steps_model", steps_done, exp_steps);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
